// File: rtl/count_monitor.sv
// count_monitor
//   Samples a free-running ripple-counter value from another timing domain,
//   accepts a value only after it has settled for two consecutive samples,
//   and reports updates, wraps, a match value, skipped counts and a
//   saturating wrap tally.
//
// Ports
//   clk         in   sampling clock, rising edge
//   rst         in   synchronous reset, active low
//   cnt_in      in   [WIDTH-1:0] raw, possibly mid-ripple counter value
//   clr         in   clears wrap_count, ovf, err_skip
//   cnt_sync    out  [WIDTH-1:0] settled clk-domain copy of cnt_in
//   upd_pulse   out  one-cycle strobe, cnt_sync changed
//   wrap_pulse  out  one-cycle strobe, cnt_sync stepped all-ones -> 0
//   match_pulse out  one-cycle strobe, cnt_sync became MATCH
//   wrap_count  out  [7:0] saturating number of wraps
//   ovf         out  sticky, wrap occurred while wrap_count saturated
//   err_skip    out  sticky, an update was not old+1
module count_monitor #(
  parameter int unsigned       WIDTH = 4,
  parameter logic [WIDTH-1:0]  MATCH = 4'hA
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt_sync,
  output logic             upd_pulse,
  output logic             wrap_pulse,
  output logic             match_pulse,
  output logic [7:0]       wrap_count,
  output logic             ovf,
  output logic             err_skip
);

  typedef enum logic {INIT, RUN} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] s1, s2, s3;
  logic [2:0]       fill;
  logic             accept;
  logic [WIDTH-1:0] sync_nxt;
  logic             upd_nxt, wrap_nxt, match_nxt, skip_ev;

  // The pipeline is zeroed by reset, so s2 == s3 holds trivially until real
  // samples have reached s3; fill tracks that so INIT never loads the reset
  // zeros instead of the first genuine settled value.
  assign accept = (s2 == s3) && fill[2];

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1   <= '0;
      s2   <= '0;
      s3   <= '0;
      fill <= '0;
    end else begin
      s1   <= cnt_in;
      s2   <= s1;
      s3   <= s2;
      fill <= {fill[1:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= INIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sync_nxt  = cnt_sync;
    upd_nxt   = 1'b0;
    wrap_nxt  = 1'b0;
    match_nxt = 1'b0;
    skip_ev   = 1'b0;
    case (state)
      INIT: begin
        if (accept) begin
          sync_nxt  = s3;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (accept && (s3 != cnt_sync)) begin
          sync_nxt  = s3;
          upd_nxt   = 1'b1;
          wrap_nxt  = (cnt_sync == '1) && (s3 == '0);
          match_nxt = (s3 == MATCH);
          skip_ev   = (s3 != WIDTH'(cnt_sync + 1'b1));
        end
      end
      default: state_nxt = INIT;
    endcase
  end

  // Pulses are registered alongside cnt_sync so they coincide with the
  // cycle in which the new value is visible.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_sync    <= '0;
      upd_pulse   <= 1'b0;
      wrap_pulse  <= 1'b0;
      match_pulse <= 1'b0;
    end else begin
      cnt_sync    <= sync_nxt;
      upd_pulse   <= upd_nxt;
      wrap_pulse  <= wrap_nxt;
      match_pulse <= match_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wrap_count <= '0;
      ovf        <= 1'b0;
      err_skip   <= 1'b0;
    end else if (clr) begin
      wrap_count <= '0;
      ovf        <= 1'b0;
      err_skip   <= 1'b0;
    end else begin
      if (wrap_nxt) begin
        if (wrap_count == 8'hFF) begin
          ovf <= 1'b1;
        end else begin
          wrap_count <= wrap_count + 8'd1;
        end
      end
      if (skip_ev) begin
        err_skip <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_count_monitor.sv
// tb_count_monitor
//   Directed bench for count_monitor: reset state, load latency, increments,
//   wrap, match, glitch rejection, skip detection, clear, saturation and
//   mid-operation reset.
module tb_count_monitor;

  logic       clk;
  logic       rst;
  logic [3:0] cnt_in;
  logic       clr;
  logic [3:0] cnt_sync;
  logic       upd_pulse;
  logic       wrap_pulse;
  logic       match_pulse;
  logic [7:0] wrap_count;
  logic       ovf;
  logic       err_skip;

  int errors = 0;
  int checks = 0;
  int n_upd, n_wrap, n_match;

  count_monitor #(.WIDTH(4), .MATCH(4'hA)) dut (
    .clk(clk),
    .rst(rst),
    .cnt_in(cnt_in),
    .clr(clr),
    .cnt_sync(cnt_sync),
    .upd_pulse(upd_pulse),
    .wrap_pulse(wrap_pulse),
    .match_pulse(match_pulse),
    .wrap_count(wrap_count),
    .ovf(ovf),
    .err_skip(err_skip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock, then sample 1 time unit after the edge; tallies pulses seen.
  task automatic tick();
    @(posedge clk);
    #1;
    n_upd   += int'(upd_pulse);
    n_wrap  += int'(wrap_pulse);
    n_match += int'(match_pulse);
  endtask

  task automatic advance(input logic [3:0] v, input int n);
    cnt_in = v;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_tally();
    n_upd = 0; n_wrap = 0; n_match = 0;
  endtask

  initial begin
    rst = 1'b0; clr = 1'b0; cnt_in = 4'h5;
    clear_tally();
    tick(); tick();
    check("rst_cnt_sync", 32'(cnt_sync), 32'h0);
    check("rst_pulses", {29'd0, upd_pulse, wrap_pulse, match_pulse}, 32'h0);
    check("rst_wrap_count", 32'(wrap_count), 32'h0);
    check("rst_flags", {30'd0, ovf, err_skip}, 32'h0);

    // Load latency after release.
    rst = 1'b1;
    clear_tally();
    tick(); tick(); tick();
    check("load_not_yet", 32'(cnt_sync), 32'h0);
    tick();
    check("load_cnt_sync", 32'(cnt_sync), 32'h5);
    tick(); tick();
    check("load_silent_upd", 32'(n_upd), 32'd0);
    check("load_silent_match", 32'(n_match), 32'd0);
    check("load_no_err", 32'(err_skip), 32'h0);

    // Step 6..E: nine updates, one match at A lasting a single cycle.
    clear_tally();
    for (int v = 6; v <= 14; v++) advance(4'(v), 5);
    check("inc_cnt_sync", 32'(cnt_sync), 32'hE);
    check("inc_upd_count", 32'(n_upd), 32'd9);
    check("match_once", 32'(n_match), 32'd1);
    check("inc_no_wrap", 32'(n_wrap), 32'd0);
    check("inc_no_err", 32'(err_skip), 32'h0);

    // E -> F -> 0 wraps once.
    clear_tally();
    advance(4'hF, 5);
    advance(4'h0, 5);
    check("wrap_upd_count", 32'(n_upd), 32'd2);
    check("wrap_pulse_count", 32'(n_wrap), 32'd1);
    check("wrap_count_1", 32'(wrap_count), 32'd1);
    check("wrap_no_err", 32'(err_skip), 32'h0);

    // Up to 7, then a one-cycle glitch to 4 before settling on 8.
    for (int v = 1; v <= 7; v++) advance(4'(v), 5);
    clear_tally();
    advance(4'h4, 1);
    advance(4'h8, 5);
    check("glitch_single_upd", 32'(n_upd), 32'd1);
    check("glitch_cnt_sync", 32'(cnt_sync), 32'h8);
    check("glitch_no_err", 32'(err_skip), 32'h0);

    // 9..F,0..3 then jump 3 -> 6.
    for (int v = 9; v <= 15; v++) advance(4'(v), 5);
    for (int v = 0; v <= 3; v++) advance(4'(v), 5);
    check("wrap_count_2", 32'(wrap_count), 32'd2);
    check("pre_skip_err", 32'(err_skip), 32'h0);
    clear_tally();
    advance(4'h6, 5);
    check("skip_cnt_sync", 32'(cnt_sync), 32'h6);
    check("skip_upd", 32'(n_upd), 32'd1);
    check("skip_err_set", 32'(err_skip), 32'h1);
    advance(4'h7, 5);
    check("skip_err_sticky", 32'(err_skip), 32'h1);
    clr = 1'b1; tick(); clr = 1'b0;
    check("clr_err", 32'(err_skip), 32'h0);
    check("clr_wrap_count", 32'(wrap_count), 32'h0);
    tick();
    check("clr_keeps_sync", 32'(cnt_sync), 32'h7);

    // A skip landing on 0 from a non-all-ones value is not a wrap.
    clear_tally();
    advance(4'h0, 5);
    check("skip0_no_wrap", 32'(n_wrap), 32'd0);
    check("skip0_wrap_count", 32'(wrap_count), 32'd0);

    // Saturation: 255 wraps reach FF, further wraps set ovf.
    for (int i = 0; i < 255; i++) begin
      advance(4'hF, 5);
      advance(4'h0, 5);
    end
    check("sat_wrap_count", 32'(wrap_count), 32'hFF);
    check("sat_no_ovf_yet", 32'(ovf), 32'h0);
    for (int i = 0; i < 2; i++) begin
      advance(4'hF, 5);
      advance(4'h0, 5);
    end
    check("sat_hold", 32'(wrap_count), 32'hFF);
    check("sat_ovf", 32'(ovf), 32'h1);

    // clr coincident with the edge that registers a wrap.
    advance(4'hF, 5);
    advance(4'h0, 3);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clrwrap_pulse", 32'(wrap_pulse), 32'h1);
    check("clrwrap_count", 32'(wrap_count), 32'h0);
    check("clrwrap_ovf", 32'(ovf), 32'h0);

    // Reset with a sample in flight, then a silent reload.
    cnt_in = 4'h1;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("midrst_cnt_sync", 32'(cnt_sync), 32'h0);
    check("midrst_pulses", {29'd0, upd_pulse, wrap_pulse, match_pulse}, 32'h0);
    check("midrst_flags", {22'd0, wrap_count, ovf, err_skip}, 32'h0);
    tick();
    rst = 1'b1;
    clear_tally();
    advance(4'h1, 4);
    check("reload_cnt_sync", 32'(cnt_sync), 32'h1);
    advance(4'h1, 3);
    check("reload_silent", 32'(n_upd + n_wrap + n_match), 32'd0);
    check("reload_no_err", 32'(err_skip), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
